// File: rtl/dmem_ctrl.sv
// Byte-addressable 32-bit data memory controller with selectable endianness.
// After reset it zero-fills every word, then serves one load/store per cycle.
module dmem_ctrl #(
    parameter int ADDR_BITS  = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rsp_load_q, rsp_load_d;
    logic [1:0]             rsp_size_q, rsp_size_d;
    logic [1:0]             rsp_pos_q, rsp_pos_d;
    logic                   rsp_uns_q, rsp_uns_d;

    logic [ADDR_BITS-1:0]   req_idx;
    logic [1:0]             req_off;
    logic                   req_err;
    logic [1:0]             req_pos;
    logic [3:0]             req_be;
    logic [31:0]            req_lane_data;

    logic [ADDR_BITS-1:0]   wr_idx;
    logic [3:0]             wr_be;
    logic [31:0]            wr_data;
    logic [31:0]            rd_word;
    logic [31:0]            rd_shift;

    // req_pos is the byte lane (bit 8*pos) holding the least significant byte of the access.
    always_comb begin
        req_idx       = req_addr[ADDR_BITS+1:2];
        req_off       = req_addr[1:0];
        req_err       = |req_addr[31:ADDR_BITS+2];
        req_pos       = 2'd0;
        req_be        = 4'h0;
        req_lane_data = req_wdata;
        case (req_size)
            2'b00: begin
                req_pos       = BIG_ENDIAN ? (2'd3 - req_off) : req_off;
                req_be        = 4'b0001 << req_pos;
                req_lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_err       = req_err | req_off[0];
                req_pos       = {(BIG_ENDIAN ? ~req_off[1] : req_off[1]), 1'b0};
                req_be        = 4'b0011 << req_pos;
                req_lane_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_err = req_err | (|req_off);
                req_be  = 4'hF;
            end
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        req_ready   = 1'b0;
        busy        = 1'b0;
        wr_idx      = req_idx;
        wr_be       = 4'h0;
        wr_data     = req_lane_data;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_load_d  = 1'b0;
        rsp_size_d  = req_size;
        rsp_pos_d   = req_pos;
        rsp_uns_d   = req_unsigned;
        case (state_q)
            S_CLEAR: begin
                busy      = 1'b1;
                wr_idx    = clr_idx_q;
                wr_be     = 4'hF;
                wr_data   = 32'h0;
                clr_idx_d = clr_idx_q + ADDR_BITS'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = req_err;
                    rsp_load_d  = !req_we && !req_err;
                    if (req_we && !req_err) begin
                        wr_be = req_be;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_size_q  <= 2'd0;
            rsp_pos_q   <= 2'd0;
            rsp_uns_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
            rsp_size_q  <= rsp_size_d;
            rsp_pos_q   <= rsp_pos_d;
            rsp_uns_q   <= rsp_uns_d;
        end
    end

    // One byte-wide RAM per lane gives a byte-masked write with a registered read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] rd_byte_q;
            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    ram[wr_idx] <= wr_data[8*gi +: 8];
                end
                rd_byte_q <= ram[req_idx];
            end
            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

    always_comb begin
        rd_shift  = rd_word >> {rsp_pos_q, 3'b000};
        rsp_rdata = 32'h0;
        if (rsp_valid_q && rsp_load_q) begin
            case (rsp_size_q)
                2'b00:   rsp_rdata = rsp_uns_q ? {24'h0, rd_shift[7:0]}
                                               : {{24{rd_shift[7]}}, rd_shift[7:0]};
                2'b01:   rsp_rdata = rsp_uns_q ? {16'h0, rd_shift[15:0]}
                                               : {{16{rd_shift[15]}}, rd_shift[15:0]};
                default: rsp_rdata = rd_shift;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a big-endian and a little-endian instance
// (ADDR_BITS = 4) receive the same requests and are checked against hand values.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready_be, rsp_valid_be, rsp_err_be, busy_be;
    logic [31:0] rsp_rdata_be;
    logic        req_ready_le, rsp_valid_le, rsp_err_le, busy_le;
    logic [31:0] rsp_rdata_le;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_BITS(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_be),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_be),
        .rsp_rdata(rsp_rdata_be), .rsp_err(rsp_err_be), .busy(busy_be)
    );

    dmem_ctrl #(.ADDR_BITS(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_le),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_le),
        .rsp_rdata(rsp_rdata_le), .rsp_err(rsp_err_le), .busy(busy_le)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd_be;
        logic [31:0] rd_le;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        $display("txn %-10s we=%0d size=%0d addr=0x%08h wdata=0x%08h | be: v=%0d err=%0d rd=0x%08h | le: v=%0d err=%0d rd=0x%08h",
                 v.name, v.we, v.size, v.addr, v.wdata, rsp_valid_be, rsp_err_be, rsp_rdata_be,
                 rsp_valid_le, rsp_err_le, rsp_rdata_le);
        check({v.name, " be valid"}, 32'(rsp_valid_be), 32'd1);
        check({v.name, " be err"},   32'(rsp_err_be),   32'(v.err));
        check({v.name, " be rdata"}, rsp_rdata_be,      v.rd_be);
        check({v.name, " le valid"}, 32'(rsp_valid_le), 32'd1);
        check({v.name, " le err"},   32'(rsp_err_le),   32'(v.err));
        check({v.name, " le rdata"}, rsp_rdata_le,      v.rd_le);
    endtask

    // Counts rising edges until busy drops; requests held during clear must be ignored.
    task automatic wait_clear(input string name);
        int n = 0;
        int stray = 0;
        while (busy_be && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid_be || rsp_valid_le) stray++;
            if (busy_be && (req_ready_be || req_ready_le)) stray++;
        end
        req_valid = 1'b0;
        $display("txn %-10s clear cycles=%0d stray=%0d", name, n, stray);
        check({name, " cycles"},   32'(n),       32'd16);
        check({name, " stray"},    32'(stray),   32'd0);
        check({name, " le busy"},  32'(busy_le), 32'd0);
        check({name, " be ready"}, 32'(req_ready_be), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{"sw8",     1'b1, 2'd2, 1'b0, 32'h8,        32'h11223344, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{"lbu9",    1'b0, 2'd0, 1'b1, 32'h9,        32'h0,        1'b0, 32'h22,       32'h33};
        vecs[2]  = '{"lhA",     1'b0, 2'd1, 1'b0, 32'hA,        32'h0,        1'b0, 32'h3344,     32'h1122};
        vecs[3]  = '{"sbB",     1'b1, 2'd0, 1'b0, 32'hB,        32'h80,       1'b0, 32'h0,        32'h0};
        vecs[4]  = '{"lbB",     1'b0, 2'd0, 1'b0, 32'hB,        32'h0,        1'b0, 32'hFFFFFF80, 32'hFFFFFF80};
        vecs[5]  = '{"lw8",     1'b0, 2'd2, 1'b0, 32'h8,        32'h0,        1'b0, 32'h11223380, 32'h80223344};
        vecs[6]  = '{"sw0",     1'b1, 2'd2, 1'b0, 32'h0,        32'h11223344, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{"lbu0",    1'b0, 2'd0, 1'b1, 32'h0,        32'h0,        1'b0, 32'h11,       32'h44};
        vecs[8]  = '{"lhu2",    1'b0, 2'd1, 1'b1, 32'h2,        32'h0,        1'b0, 32'h3344,     32'h1122};
        vecs[9]  = '{"sw4",     1'b1, 2'd2, 1'b0, 32'h4,        32'hAABBCCDD, 1'b0, 32'h0,        32'h0};
        vecs[10] = '{"sh6",     1'b1, 2'd1, 1'b0, 32'h6,        32'h00001234, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{"lw4",     1'b0, 2'd2, 1'b0, 32'h4,        32'h0,        1'b0, 32'hAABB1234, 32'h1234CCDD};
        vecs[12] = '{"lh4",     1'b0, 2'd1, 1'b0, 32'h4,        32'h0,        1'b0, 32'hFFFFAABB, 32'hFFFFCCDD};
        vecs[13] = '{"lhu4",    1'b0, 2'd1, 1'b1, 32'h4,        32'h0,        1'b0, 32'h0000AABB, 32'h0000CCDD};
        vecs[14] = '{"lw2err",  1'b0, 2'd2, 1'b0, 32'h2,        32'h0,        1'b1, 32'h0,        32'h0};
        vecs[15] = '{"sh1err",  1'b1, 2'd1, 1'b0, 32'h1,        32'hFFFFFFFF, 1'b1, 32'h0,        32'h0};
        vecs[16] = '{"sz3err",  1'b1, 2'd3, 1'b0, 32'h4,        32'hFFFFFFFF, 1'b1, 32'h0,        32'h0};
        vecs[17] = '{"sw40err", 1'b1, 2'd2, 1'b0, 32'h40,       32'hFFFFFFFF, 1'b1, 32'h0,        32'h0};
        vecs[18] = '{"lw40err", 1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        1'b1, 32'h0,        32'h0};
        vecs[19] = '{"swhierr", 1'b1, 2'd2, 1'b0, 32'h80000000, 32'hDEADBEEF, 1'b1, 32'h0,        32'h0};
        vecs[20] = '{"lw0rb",   1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 32'h11223344, 32'h11223344};
        vecs[21] = '{"lw4rb",   1'b0, 2'd2, 1'b0, 32'h4,        32'h0,        1'b0, 32'hAABB1234, 32'h1234CCDD};
        vecs[22] = '{"sb0",     1'b1, 2'd0, 1'b0, 32'h0,        32'h0000017F, 1'b0, 32'h0,        32'h0};
        vecs[23] = '{"lb0",     1'b0, 2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h7F,       32'h7F};
        vecs[24] = '{"lw0",     1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 32'h7F223344, 32'h1122337F};

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst be ready", 32'(req_ready_be), 32'd0);
        check("rst be valid", 32'(rsp_valid_be), 32'd0);
        check("rst be err",   32'(rsp_err_be),   32'd0);
        check("rst be rdata", rsp_rdata_be,      32'h0);
        check("rst be busy",  32'(busy_be),      32'd1);
        check("rst le busy",  32'(busy_le),      32'd1);
        check("rst le ready", 32'(req_ready_le), 32'd0);

        // A load is held valid throughout the clear and must get no response.
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b1; req_addr = 32'h3C;
        wait_clear("clear1");
        do_req('{"lw3C", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h0, 32'h0});

        for (int i = 0; i < 25; i++) begin
            do_req(vecs[i]);
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pulse end be", 32'(rsp_valid_be), 32'd0);
        check("pulse end le", 32'(rsp_valid_le), 32'd0);

        // Reset again, then interrupt the clear at index 5.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        check("midclr busy",  32'(busy_be),      32'd1);
        check("midclr ready", 32'(req_ready_be), 32'd0);
        check("midclr valid", 32'(rsp_valid_be), 32'd0);
        @(negedge clk); reset = 1'b0;
        wait_clear("clear2");

        do_req('{"sw8b", 1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0});
        // Reset lands right after a load is accepted: its response must vanish.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        $display("txn %-10s reset after accept: be v=%0d rd=0x%08h", "pendld", rsp_valid_be, rsp_rdata_be);
        check("pend be valid", 32'(rsp_valid_be), 32'd0);
        check("pend be rdata", rsp_rdata_be,      32'h0);
        check("pend le valid", 32'(rsp_valid_le), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        wait_clear("clear3");
        do_req('{"lw8clr", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 32'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within 200000 ns");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_BITS: default 10. Word-address width; depth is 2**ADDR_BITS 32-bit words.
REQ-002 Parameter BIG_ENDIAN: default 1. Selects byte-lane order: 1 = big-endian, 0 = little-endian.
REQ-003 Port clk: input, 1 bit. Single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1 bit. Asynchronous, active-high reset.
REQ-005 Port req_valid: input, 1 bit. Request present.
REQ-006 Port req_ready: output, 1 bit. Block accepts a request this cycle.
REQ-007 Port req_we: input, 1 bit. 1 = store, 0 = load.
REQ-008 Port req_size: input, 2 bits. 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-009 Port req_unsigned: input, 1 bit. For loads: 1 = zero-extend, 0 = sign-extend.
REQ-010 Port req_addr: input, 32 bits. Byte address.
REQ-011 Port req_wdata: input, 32 bits. Store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid: output, 1 bit. One-cycle response pulse.
REQ-013 Port rsp_rdata: output, 32 bits. Extended load data; 0 for stores and for errors.
REQ-014 Port rsp_err: output, 1 bit. Request rejected (misaligned, out of range, or illegal size).
REQ-015 Port busy: output, 1 bit. High while the post-reset clear sequence runs.

Function
REQ-016 The block SHALL have two states, CLEAR and IDLE; reset forces CLEAR with the clear index at 0.
REQ-017 In CLEAR, the block SHALL write word[index] = 0 each cycle, increment the index, and move to IDLE after writing index 2**ADDR_BITS-1 (2**ADDR_BITS cycles in total).
REQ-018 In CLEAR: busy = 1, req_ready = 0, and requests are ignored with no response.
REQ-019 In IDLE: busy = 0 and req_ready = 1; a request is accepted when req_valid && req_ready.
REQ-020 Every accepted request SHALL produce exactly one rsp_valid pulse in the following cycle (latency 1). There is no response backpressure. Back-to-back requests give back-to-back responses.
REQ-021 An error SHALL be flagged if any of the following holds:
- req_size == 11;
- size half and addr[0] != 0;
- size word and addr[1:0] != 0;
- addr[31:ADDR_BITS+2] != 0.
REQ-022 On an error: no memory write, rsp_err = 1, rsp_rdata = 0.
REQ-023 Addressing: word index = addr[ADDR_BITS+1:2]; byte offset k = addr[1:0].
REQ-024 Byte lanes: offset k occupies bits [31-8k -: 8] when BIG_ENDIAN = 1, and [8k+7 -: 8] when BIG_ENDIAN = 0. Halves occupy offsets k and k+1, with the lower address holding the more significant byte when BIG_ENDIAN = 1.
REQ-025 Stores SHALL modify only the addressed byte(s); the other lanes of the word SHALL be preserved (byte-masked write).
REQ-026 Word stores SHALL use the lane order of REQ-024, so that wdata 0x11223344 written with BIG_ENDIAN = 1 reads back as byte 0 = 0x11.
REQ-027 Loads SHALL extract the addressed byte, half or word per REQ-024, then sign- or zero-extend it to 32 bits per req_unsigned (req_unsigned is ignored for word loads).
REQ-028 A store response SHALL have rsp_err = 0 and rsp_rdata = 0.
REQ-029 A load issued in the cycle after a store to the same word SHALL return the updated data.
REQ-030 Out-of-range addresses SHALL never alias or wrap into valid words.

Reset
REQ-031 While reset is asserted, outputs SHALL be: req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = 1.
REQ-032 Memory contents are undefined until CLEAR completes; after CLEAR, every word reads as 0.
REQ-033 Reset asserted mid-CLEAR or mid-IDLE SHALL abort immediately, drop any pending response, and restart CLEAR from index 0 once reset deasserts.

Verification
REQ-034 Clear sequence (ADDR_BITS = 4): release reset -> busy = 1 for exactly 16 cycles, then req_ready = 1; a load of word 0x3C returns rsp_rdata = 0.
REQ-035 Big-endian store/load (BIG_ENDIAN = 1): SW 0x11223344 @0x8; LBU @0x9 -> 0x22; LH @0xA -> 0x00003344; LB after SB 0x80 @0xB -> 0xFFFFFF80.
REQ-036 Little-endian (BIG_ENDIAN = 0): SW 0x11223344 @0x0; LBU @0x0 -> 0x44; LHU @0x2 -> 0x1122.
REQ-037 Partial store: SW 0xAABBCCDD @0x4, SH 0x1234 @0x6 (BIG_ENDIAN = 1); LW @0x4 -> 0xAABB1234.
REQ-038 Errors: LW @0x2, SH @0x1, req_size = 11, and LW @(4 << ADDR_BITS) each -> rsp_err = 1, rsp_rdata = 0, and memory unchanged on readback.
REQ-039 Reset mid-operation: assert reset during CLEAR index 5 and again during a pending load -> no rsp_valid, and CLEAR restarts at 0 with the full duration.
